// File: rtl/a2d_intf.sv
// SPI master for an ADC128S-style converter: a channel-address frame followed by a
// result frame, with the 12-bit result and a sticky completion flag for the requester.
module a2d_intf #(
  parameter int SCLK_DIV_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int N = SCLK_DIV_LOG2;
  localparam int P = 1 << N;
  // Preloading 3P/4 puts the first SCLK fall P/4 clocks after SS_n drops.
  localparam logic [N-1:0] DIV_START = N'(3 * P / 4);
  localparam logic [N-1:0] DIV_RISE  = N'(P / 2 - 1);

  typedef enum logic [1:0] {IDLE, TX1, GAP, TX2} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  div_q, div_d;
  logic [4:0]    fall_q, fall_d;
  logic [15:0]   shreg_q, shreg_d;
  logic          miso_q, miso_d;
  logic [2:0]    chnl_q, chnl_d;
  logic          ss_n_q, ss_n_d;
  logic          sclk_q, sclk_d;
  logic          cmplt_q, cmplt_d;
  logic [11:0]   res_q, res_d;
  logic          gap_q, gap_d;
  logic          tx, fall_edge, rise_edge, launch;
  logic [2:0]    launch_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      fall_q  <= '0;
      shreg_q <= '0;
      miso_q  <= 1'b0;
      chnl_q  <= '0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      cmplt_q <= 1'b0;
      res_q   <= '0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      fall_q  <= fall_d;
      shreg_q <= shreg_d;
      miso_q  <= miso_d;
      chnl_q  <= chnl_d;
      ss_n_q  <= ss_n_d;
      sclk_q  <= sclk_d;
      cmplt_q <= cmplt_d;
      res_q   <= res_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fall_d    = fall_q;
    shreg_d   = shreg_q;
    chnl_d    = chnl_q;
    ss_n_d    = ss_n_q;
    cmplt_d   = cmplt_q;
    res_d     = res_q;
    gap_d     = gap_q;
    launch    = 1'b0;
    launch_ch = chnl_q;

    tx        = (state_q == TX1) || (state_q == TX2);
    fall_edge = tx && (div_q == '1);
    rise_edge = tx && (div_q == DIV_RISE);
    div_d     = tx ? div_q + 1'b1 : div_q;
    miso_d    = rise_edge ? MISO : miso_q;

    case (state_q)
      IDLE: begin
        if (strt_cnv) begin
          chnl_d    = chnnl;
          launch    = 1'b1;
          launch_ch = chnnl;
          cmplt_d   = 1'b0;
          state_d   = TX1;
        end
      end
      TX1, TX2: begin
        if (fall_edge) begin
          // The very first fall only starts the frame; every later one shifts.
          if (fall_q != 5'd0) shreg_d = {shreg_q[14:0], miso_q};
          fall_d = fall_q + 5'd1;
          if (fall_q == 5'd16) begin
            ss_n_d = 1'b1;
            if (state_q == TX1) begin
              gap_d   = 1'b0;
              state_d = GAP;
            end else begin
              res_d   = {shreg_q[10:0], miso_q};
              cmplt_d = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_q) begin
          launch  = 1'b1;
          state_d = TX2;
        end else begin
          gap_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      ss_n_d  = 1'b0;
      div_d   = DIV_START;
      fall_d  = 5'd0;
      shreg_d = {2'b00, launch_ch, 11'h000};
    end

    // Registered SCLK keeps the pin glitch-free across SS_n edges.
    sclk_d = ss_n_d ? 1'b1 : div_d[N-1];
  end

  assign SS_n      = ss_n_q;
  assign SCLK      = sclk_q;
  assign MOSI      = ((state_q == TX1) || (state_q == TX2)) ? shreg_q[15] : 1'b0;
  assign cnv_cmplt = cmplt_q;
  assign res       = res_q;

endmodule
